// File: rtl/crc_accum_pkg.sv
// Shared types, constants and the word-wide CRC-32 step for the CRC accumulator.
package crc_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Reflected CRC-32 over one word: byte 0 first, each byte LSB first,
    // which is simply data bit 0 through bit 31 in order.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_fifo.sv
// Synchronous FIFO with registered occupancy; full blocks pushes even when a pop
// happens in the same cycle, so there is no ready pass-through.
module crc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/crc_accum.sv
// Packet CRC-32 accumulator: words are queued in a FIFO and folded into the CRC
// one per cycle once a packet has been started with new_data.
//
// state | meaning
// IDLE  | waiting for new_data; queued words are held, not consumed
// ACCUM | popping one word per cycle into the CRC until the last word
// DONE  | one-cycle crc_done pulse, then back to IDLE
module crc_accum
    import crc_accum_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        new_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_src,
    input  logic        in_last,
    output logic        push_a_done,
    output logic        push_b_done,
    output logic        crc_done,
    output logic [31:0] crc_value,
    output logic [15:0] word_cnt
);

    crc_state_t  state;
    crc_state_t  next_state;
    logic        fifo_full;
    logic        fifo_empty;
    logic [32:0] fifo_rd;
    logic        accept;
    logic        pop;
    logic        load;
    logic        pop_last;
    logic [31:0] crc_reg;
    logic [31:0] next_crc;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign pop_last = fifo_rd[0];
    assign next_crc = crc32_word(crc_reg, fifo_rd[32:1]);
    assign crc_done = (state == DONE);

    crc_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(33)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (accept),
        .push_data({in_data, in_last}),
        .pop      (pop),
        .pop_data (fifo_rd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (new_data) begin
                    load       = 1'b1;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (pop_last) next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_reg     <= CRC_INIT;
            crc_value   <= '0;
            word_cnt    <= '0;
            push_a_done <= 1'b0;
            push_b_done <= 1'b0;
        end else begin
            push_a_done <= accept && !in_src;
            push_b_done <= accept && in_src;
            if (load) begin
                crc_reg  <= CRC_INIT;
                word_cnt <= '0;
            end else if (pop) begin
                crc_reg <= next_crc;
                if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                if (pop_last) crc_value <= ~next_crc;
            end
        end
    end

endmodule

// File: doc/crc_accum.md
CRC_ACCUM -- requirements
Module: crc_accum

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning input FIFO entry count; power of two, minimum 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 new_data  input  1  single-cycle start-of-packet pulse.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  FIFO can accept a word.
REQ-007 in_data  input  32  data word; byte 0 = bits 7:0.
REQ-008 in_src  input  1  source tag: 0 = channel A, 1 = channel B.
REQ-009 in_last  input  1  marks the final word of the packet.
REQ-010 push_a_done  output  1  one-cycle pulse: channel A word accepted.
REQ-011 push_b_done  output  1  one-cycle pulse: channel B word accepted.
REQ-012 crc_done  output  1  one-cycle pulse: packet CRC final.
REQ-013 crc_value  output  32  final CRC of the last completed packet.
REQ-014 word_cnt  output  16  words consumed in the current or last packet.

Function
REQ-015 A word SHALL be accepted when in_valid and in_ready are both 1; {in_data, in_last} SHALL be written to the FIFO that cycle.
REQ-016 in_ready SHALL equal (FIFO count < FIFO_DEPTH), with no pass-through; a full FIFO SHALL deassert in_ready even when a pop occurs in the same cycle.
REQ-017 push_a_done or push_b_done, selected by in_src, SHALL be registered and high for exactly the one cycle after the accepting edge; the two SHALL never be high together.
REQ-018 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-019 In IDLE, new_data SHALL load the CRC register with 0xFFFFFFFF, clear word_cnt and move to ACCUM; it SHALL NOT pop the FIFO in that cycle.
REQ-020 In IDLE, accepted words SHALL remain queued and SHALL NOT be consumed.
REQ-021 In ACCUM with the FIFO non-empty, one word SHALL be popped per cycle and the CRC register updated.
REQ-022 The CRC SHALL be CRC-32, reflected, polynomial 0xEDB88320, processing byte 0 first and LSB first.
REQ-023 Each pop SHALL increment word_cnt, saturating at 0xFFFF.
REQ-024 Popping a word with in_last=1 SHALL register crc_value = ~next_crc and move to DONE.
REQ-025 In DONE, crc_done SHALL be 1 for exactly one cycle, with no pop; the next state SHALL be IDLE.
REQ-026 crc_value and word_cnt SHALL hold until overwritten by the next packet.
REQ-027 new_data SHALL be ignored in ACCUM and DONE.
REQ-028 An empty FIFO in ACCUM SHALL stall the FSM with no CRC change.
REQ-029 Push and pop in the same cycle SHALL leave the FIFO count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 On rstn low, the FSM SHALL enter IDLE and the FIFO SHALL be emptied, so in_ready = 1.
REQ-031 On rstn low, crc_value, word_cnt, crc_done, push_a_done and push_b_done SHALL all be 0, and the CRC register SHALL be 0xFFFFFFFF.
REQ-032 Reset asserted mid-packet SHALL discard the partial CRC and queued words, and SHALL produce no crc_done.

Structure
REQ-033 A shared package SHALL hold:
- the state enum crc_state_t {IDLE, ACCUM, DONE};
- CRC_POLY = 0xEDB88320 and CRC_INIT = 0xFFFFFFFF;
- a function crc32_word(crc, data) returning the next CRC.
REQ-034 The FIFO SHALL be a sub-module named crc_fifo, parameterised by depth and width (33 bits).

Verification
REQ-035 new_data, then one word 0x00000000 with in_last=1 -> crc_done once; crc_value = 0x2144DF1C; word_cnt = 1.
REQ-036 new_data, then word 0x34333231 ("1234") with last -> crc_value = 0x9BE3E0A3.
REQ-037 Push 4 words in IDLE with no new_data:
- in_ready falls after the 4th word;
- the 5th in_valid stalls;
- new_data then drains the FIFO 1 word per cycle, and in_ready returns the cycle after the first pop.
REQ-038 Alternate in_src 0,1,0,1 on back-to-back words -> push_a_done and push_b_done alternate, each one cycle, never overlapping.
REQ-039 Assert rstn low after 2 of 3 words of a packet -> FIFO empty, state IDLE, no crc_done, crc_value = 0.
REQ-040 Two packets back-to-back, with new_data pulsed in the same cycle as crc_done -> the pulse is ignored, the second packet waits in IDLE, and crc_value holds until the second packet completes.
